// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  localparam int MULDIV_ITER = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/response bundle between the core's decode stage and the HI/LO unit.
interface mips_muldiv_if;
  import mips_muldiv_pkg::*;

  // start/op/rs_value/rt_value are sampled on a rising edge only while busy is
  // low; a start seen while busy is high is dropped, never queued. done pulses
  // for one cycle when hi/lo have just been written; hi/lo are stale while busy.
  logic        start;
  muldiv_op_t  op;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_value, rt_value,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_value, rt_value,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_signed_mag.sv
// Conditional two's-complement negation; yields |x| for operands and applies
// the result sign at fix-up. sign_o reports the input's MSB.
module muldiv_signed_mag #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] result_o,
  output logic         sign_o
);

  assign result_o = negate_i ? ((~value_i) + {{(W-1){1'b0}}, 1'b1}) : value_i;
  assign sign_o   = value_i[W-1];

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per enabled clock, sign fix-up at the end.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int          ITER       = MULDIV_ITER,
  parameter logic [31:0] RESET_HILO = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  mips_muldiv_if.slave  bus,
  output muldiv_state_t dbg_state_o
);

  localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

  muldiv_state_t state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   mcand_q, mcand_d;
  logic          is_div_q, is_div_d;
  logic          neg_lo_q, neg_lo_d;
  logic          neg_hi_q, neg_hi_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  logic        op_signed, op_div;
  logic [31:0] rs_mag, rt_mag;
  logic        rs_sign, rt_sign;
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed, rem_fixed;
  logic        prod_sign_unused, quo_sign_unused, rem_sign_unused;
  logic        sign_unused;

  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

  muldiv_signed_mag #(.W(32)) u_rs_mag (
    .value_i  (bus.rs_value),
    .negate_i (op_signed & bus.rs_value[31]),
    .result_o (rs_mag),
    .sign_o   (rs_sign)
  );

  muldiv_signed_mag #(.W(32)) u_rt_mag (
    .value_i  (bus.rt_value),
    .negate_i (op_signed & bus.rt_value[31]),
    .result_o (rt_mag),
    .sign_o   (rt_sign)
  );

  muldiv_signed_mag #(.W(64)) u_prod_fix (
    .value_i  (acc_q),
    .negate_i (neg_lo_q),
    .result_o (prod_fixed),
    .sign_o   (prod_sign_unused)
  );

  muldiv_signed_mag #(.W(32)) u_quo_fix (
    .value_i  (acc_q[31:0]),
    .negate_i (neg_lo_q),
    .result_o (quo_fixed),
    .sign_o   (quo_sign_unused)
  );

  muldiv_signed_mag #(.W(32)) u_rem_fix (
    .value_i  (acc_q[63:32]),
    .negate_i (neg_hi_q),
    .result_o (rem_fixed),
    .sign_o   (rem_sign_unused)
  );

  assign sign_unused = prod_sign_unused ^ quo_sign_unused ^ rem_sign_unused;

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : 32'h0)};
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MTHI: begin
              hi_d   = bus.rs_value;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.rs_value;
              done_d = 1'b1;
            end
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              if (op_div && (bus.rt_value == 32'h0)) begin
                // Divide by zero completes at once and leaves HI/LO alone.
                done_d = 1'b1;
              end else begin
                state_d  = RUN;
                cnt_d    = 6'd0;
                acc_d    = {32'h0, (op_div ? rs_mag : rt_mag)};
                mcand_d  = op_div ? rt_mag : rs_mag;
                is_div_d = op_div;
                neg_lo_d = op_signed & (rs_sign ^ rt_sign);
                neg_hi_d = op_signed & rs_sign;
              end
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (is_div_q) begin
          hi_d = rem_fixed;
          lo_d = quo_fixed;
        end else begin
          hi_d = prod_fixed[63:32];
          lo_d = prod_fixed[31:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'h0;
      mcand_q  <= 32'h0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= RESET_HILO;
      lo_q     <= RESET_HILO;
      done_q   <= 1'b0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases plus random
// operations scored against an arithmetic reference model.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_enable;
  muldiv_state_t dbg_state;

  mips_muldiv_if bus ();

  mips_muldiv_unit #(.ITER(32), .RESET_HILO(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one accepted request.
  task automatic model_issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] p;
    longint      sa, sb, q, r;
    case (op)
      3'd1: begin
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        p  = 64'(sa * sb);
        model_hi = p[63:32];
        model_lo = p[31:0];
        exp_q.push_back({model_hi, model_lo});
      end
      3'd2: begin
        p = {32'h0, rs} * {32'h0, rt};
        model_hi = p[63:32];
        model_lo = p[31:0];
        exp_q.push_back({model_hi, model_lo});
      end
      3'd3: begin
        if (rt != 32'h0) begin
          sa = longint'($signed(rs));
          sb = longint'($signed(rt));
          q  = sa / sb;
          r  = sa % sb;
          model_lo = q[31:0];
          model_hi = r[31:0];
        end
        exp_q.push_back({model_hi, model_lo});
      end
      3'd4: begin
        if (rt != 32'h0) begin
          model_lo = rs / rt;
          model_hi = rs % rt;
        end
        exp_q.push_back({model_hi, model_lo});
      end
      3'd5: begin
        model_hi = rs;
        exp_q.push_back({model_hi, model_lo});
      end
      3'd6: begin
        model_lo = rs;
        exp_q.push_back({model_hi, model_lo});
      end
      default: ;
    endcase
  endtask

  // Monitor: a done produced by an enabled, non-reset edge must match the queue head.
  initial begin
    logic        en;
    logic [63:0] e;
    forever begin
      @(posedge clk);
      en = clk_enable && !reset;
      @(negedge clk);
      if (en && bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual hi=%h lo=%h required no done", bus.hi, bus.lo);
        end else begin
          e = exp_q.pop_front();
          check("done_hilo", {bus.hi, bus.lo}, e);
          check("done_busy_low", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+#1) ----------------
  task automatic wait_idle();
    int g = 0;
    while (bus.busy === 1'b1 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: actual busy=%b required 0", bus.busy);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    wait_idle();
    bus.start    = 1'b1;
    bus.op       = muldiv_op_t'(op);
    bus.rs_value = rs;
    bus.rt_value = rt;
    model_issue(op, rs, rt);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.rs_value = $urandom;
    bus.rt_value = $urandom;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset        = 1'b1;
    clk_enable   = 1'b1;
    bus.start    = 1'b0;
    bus.op       = OP_NOP;
    bus.rs_value = 32'h0;
    bus.rt_value = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_busy",  64'(bus.busy), 64'd0);
    check("reset_done",  64'(bus.done), 64'd0);
    check("reset_hi",    64'(bus.hi),   64'd0);
    check("reset_lo",    64'(bus.lo),   64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));

    // MULTU max*max: 33 busy cycles then done.
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    measure_busy(n);
    check("multu_latency", 64'(n), 64'd33);
    check("multu_done",    64'(bus.done), 64'd1);
    check("multu_hilo",    {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

    issue(3'd1, 32'hFFFF_FFFD, 32'd7);
    wait_idle();
    check("mult_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(3'd4, 32'd7, 32'd2);
    wait_idle();
    check("divu_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("div_ovf_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    // Divide by zero: immediate done, never busy, HI/LO untouched.
    issue(3'd5, 32'hAAAA_0000, 32'h0);
    issue(3'd6, 32'h0000_5555, 32'h0);
    issue(3'd4, 32'h1234_5678, 32'h0);
    check("div0_busy", 64'(bus.busy), 64'd0);
    check("div0_done", 64'(bus.done), 64'd1);
    check("div0_hilo", {bus.hi, bus.lo}, 64'hAAAA_0000_0000_5555);

    // Start while busy is dropped.
    issue(3'd2, 32'hDEAD_BEEF, 32'h0000_0003);
    repeat (4) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.op       = OP_MTHI;
    bus.rs_value = 32'h1234_5678;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    wait_idle();
    check("busy_start_ignored_hi", 64'(bus.hi), 64'(model_hi));
    issue(3'd5, 32'h1234_5678, 32'h0);
    check("mthi_hi",   64'(bus.hi),   64'h1234_5678);
    check("mthi_done", 64'(bus.done), 64'd1);
    check("mthi_busy", 64'(bus.busy), 64'd0);

    // Reset in the middle of a divide.
    issue(3'd3, 32'h7654_3210, 32'h0000_0013);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    model_hi = 32'h0;
    model_lo = 32'h0;
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_done", 64'(bus.done), 64'd0);
    check("midreset_hilo", {bus.hi, bus.lo}, 64'h0);

    // clk_enable low for 4 cycles mid-RUN stretches latency by 4.
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (n == 5) clk_enable = 1'b0;
      if (n == 9) clk_enable = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    clk_enable = 1'b1;
    check("freeze_latency", 64'(n), 64'd37);
    check("freeze_hilo", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

    // Random operations, including NOP/reserved codes and zero divisors.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      issue(rop, ra, rb);
    end
    wait_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative HI/LO multiply/divide unit for the Harvard MIPS core, sitting beside the ALU and downstream of the register file. It takes rs/rt contents and an operation code from decode. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers that MFHI/MFLO read. It signals busy so the core can stall any HI/LO access while an operation is in flight.

Parameters:
ITER, 32, number of shift-add / restoring-divide iterations (equals the operand width; fixed at 32)
RESET_HILO, 32'h0, reset value of HI and LO

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clk_enable  in  1  when low, all state frozen (including done)
start  in  1  request; sampled on rising edge only when busy=0
op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
rs_value  in  32  multiplicand / dividend / MTHI-MTLO source
rt_value  in  32  multiplier / divisor
busy  out  1  operation in flight; HI/LO invalid to readers
done  out  1  one-cycle pulse: HI/LO just updated
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Reset (synchronous, priority over everything, including mid-operation): state=IDLE, busy=0, done=0, hi=lo=RESET_HILO, iteration counter=0.
- clk_enable=0: no register changes at all; outputs hold.
- States: IDLE, RUN, FIXUP.
- IDLE, start=1, op in {NOP, 7}: no effect; done stays 0.
- IDLE, start=1, op=MTHI or MTLO: at edge E0, hi (or lo) <= rs_value; done=1 for one cycle; busy stays 0.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU, rt_value≠0 or a multiply:
  - At E0, latch operand magnitudes and result signs; counter=0; go to RUN; busy=1.
  - Signed ops use |x|. |0x80000000| = 0x80000000, treated as unsigned.
- RUN: one iteration per enabled edge (E1..E32).
  - Multiply: 64-bit shift-add.
  - Divide: restoring, one quotient bit per edge.
  - After the ITER-th iteration, go to FIXUP.
- FIXUP (edge E33):
  - Apply sign: product negated (64-bit two's complement) if signs differ.
  - Quotient negated if sign(rs)^sign(rt); remainder takes sign(rs).
  - hi <= product[63:32] / remainder; lo <= product[31:0] / quotient.
  - busy=0, done=1 for the following cycle; return to IDLE.
- Total latency: busy high for 33 cycles after E0; results visible after E33.
- Divide by zero (DIV/DIVU with rt_value=0): at E0, no RUN; hi/lo unchanged; done=1 next cycle; busy stays 0.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps silently, no trap).
- start while busy=1 is ignored and not queued. The core must hold its request and re-assert it.
- Operands are latched at E0; rs_value/rt_value may change during RUN without effect.
- hi/lo keep their old values throughout RUN. Only FIXUP or MTHI/MTLO write them.

Decomposition:
- Package mips_muldiv_pkg:
  - op enum muldiv_op_t (NOP..MTLO codes above)
  - state enum muldiv_state_t {IDLE, RUN, FIXUP}
  - constant MULDIV_ITER=32
- Sub-module: muldiv_signed_mag (combinational abs/negate with sign output), instanced for operand magnitude and result fix-up.
- Control FSM, counter and datapath stay in mips_muldiv_unit.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles, done pulse after E33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); then DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rt=0 with hi=0xAAAA0000, lo=0x5555 -> done next cycle, busy never 1, hi/lo unchanged.
- MULTU started, new start (op=MTHI, rs=0x12345678) at iteration 5 -> ignored; after done, MTHI -> hi=0x12345678 next cycle, done=1, busy=0.
- Reset asserted at iteration 10 of DIV -> next cycle busy=0, done=0, hi=lo=0; clk_enable low for 4 cycles mid-RUN -> latency extended by exactly 4 cycles, results unchanged.
